// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the FSM state encoding and the IF/ID payload record.
package fetch_pkg;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT      = 4;

    typedef enum logic [1:0] {
        REQ,
        WAIT_RSP,
        HOLD,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory request/response channel between fetch and imem.
interface instruction_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/instruction_fetch_unit_skid_buf.sv
// One-entry skid buffer parking a fetched word while decode is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  fetch_entry_t load_entry,
    input  logic         clear,
    output logic         valid,
    output fetch_entry_t entry
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            entry <= load_entry;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch: issues PC requests, fills IF/ID,
// parks late words in a skid buffer under stall, and drops redirected fetches.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned PC_STEP      = PC_STEP_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     pc_out,
    output logic [31:0]                     pc_in,
    instruction_fetch_unit_if.master        imem,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_target,
    input  logic                            stall,
    output logic                            if_id_valid,
    output logic [31:0]                     if_id_instr,
    output logic [31:0]                     if_id_pc
);

    fetch_state_t state;
    logic [31:0]  req_pc;
    logic         req_fire;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    fetch_entry_t skid_entry;

    assign imem.imem_req_valid = reset && (state == REQ);
    assign imem.imem_req_addr  = pc_out;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    always_comb begin
        if (!reset)              pc_in = RESET_VECTOR;
        else if (redirect_valid) pc_in = align_word(redirect_target);
        else if (req_fire)       pc_in = pc_out + 32'(PC_STEP);
        else                     pc_in = pc_out;
    end

    // A response arriving while decode is full and stalled goes to the skid.
    assign skid_load  = (state == WAIT_RSP) && imem.imem_rsp_valid && stall &&
                        if_id_valid && !redirect_valid;
    assign skid_clear = redirect_valid || ((state == HOLD) && !stall);

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .load_entry ('{instr: imem.imem_rsp_data, pc: req_pc}),
        .clear      (skid_clear),
        .valid      (skid_valid),
        .entry      (skid_entry)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= REQ;
            req_pc      <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else begin
            if (!stall) if_id_valid <= 1'b0;
            case (state)
                REQ: begin
                    if (req_fire) begin
                        req_pc <= pc_out;
                        state  <= redirect_valid ? DROP : WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (redirect_valid) begin
                        state <= imem.imem_rsp_valid ? REQ : DROP;
                    end else if (imem.imem_rsp_valid) begin
                        if (skid_load) begin
                            state <= HOLD;
                        end else begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem.imem_rsp_data;
                            if_id_pc    <= req_pc;
                            state       <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        state <= REQ;
                    end else if (!stall) begin
                        if_id_valid <= skid_valid;
                        if_id_instr <= skid_entry.instr;
                        if_id_pc    <= skid_entry.pc;
                        state       <= REQ;
                    end
                end
                DROP: begin
                    // Leave only once the stale word is consumed, even if a
                    // redirect lands in the same cycle; otherwise nothing is left to wait for.
                    if (imem.imem_rsp_valid) state <= REQ;
                end
                default: state <= REQ;
            endcase
            if (redirect_valid) if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a PC register model and a
// 1-cycle instruction memory that can be swapped for hand-driven responses.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_out = 32'h0;
    logic [31:0] pc_in;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        stall = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;

    logic        ready = 1'b0;
    logic        mem_auto = 1'b1;
    logic        auto_v = 1'b0;
    logic [31:0] auto_d = 32'h0;
    logic        man_v = 1'b0;
    logic [31:0] man_d = 32'h0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = 32'h0;

    int n_chk = 0;
    int n_pass = 0;

    instruction_fetch_unit_if bus();

    assign bus.imem_req_ready = ready;
    assign bus.imem_rsp_valid = mem_auto ? auto_v : man_v;
    assign bus.imem_rsp_data  = mem_auto ? auto_d : man_d;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_out          (pc_out),
        .pc_in           (pc_in),
        .imem            (bus),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pc_out <= pc_load ? pc_load_val : pc_in;
        auto_v <= bus.imem_req_valid && bus.imem_req_ready;
        auto_d <= bus.imem_req_addr + 32'h1000_0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; mem_auto = 1'b1; man_v = 1'b0; pc_load = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ready = 1'b1; mem_auto = 1'b1; stall = 1'b0;
        redirect_valid = 1'b0; pc_load = 1'b1; pc_load_val = 32'h1234;
        tick();
        pc_load = 1'b0;
        @(negedge clk);
        n_chk++; if (pc_in !== 32'h0) $display("FAIL rst_pc_in: got %h want %h", pc_in, 32'h0); else n_pass++;
        n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); else n_pass++;
        n_chk++; if (if_id_valid !== 1'b0) $display("FAIL rst_if_id_valid: got %b want 0", if_id_valid); else n_pass++;
        n_chk++; if (if_id_instr !== 32'h0) $display("FAIL rst_if_id_instr: got %h want 0", if_id_instr); else n_pass++;
        n_chk++; if (if_id_pc !== 32'h0) $display("FAIL rst_if_id_pc: got %h want 0", if_id_pc); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (pc_in !== 32'h0) $display("FAIL rst2_pc_in: got %h want %h", pc_in, 32'h0); else n_pass++;
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.imem_req_valid !== 1'b1) $display("FAIL rel_req_valid: got %b want 1", bus.imem_req_valid); else n_pass++;
        n_chk++; if (pc_in !== 32'h4) $display("FAIL rel_pc_in: got %h want %h", pc_in, 32'h4); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            n_chk++; if (if_id_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) $display("FAIL seq_wait%0d: got valid=%b req=%b want 0 0", k, if_id_valid, bus.imem_req_valid); else n_pass++;
            tick();
            @(negedge clk);
            n_chk++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4*k)) $display("FAIL seq_pc%0d: got valid=%b pc=%h want 1 %h", k, if_id_valid, if_id_pc, 32'(4*k)); else n_pass++;
            n_chk++; if (if_id_instr !== 32'(4*k) + 32'h1000_0000) $display("FAIL seq_instr%0d: got %h want %h", k, if_id_instr, 32'(4*k) + 32'h1000_0000); else n_pass++;
        end
    endtask

    task automatic test_ready_hold();
        do_reset();
        pc_load = 1'b1; pc_load_val = 32'h100;
        tick();
        pc_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100 || pc_in !== 32'h100) $display("FAIL nrdy%0d: got req=%b addr=%h pc_in=%h want 1 100 100", i, bus.imem_req_valid, bus.imem_req_addr, pc_in); else n_pass++;
            tick();
        end
        ready = 1'b1;
        @(negedge clk);
        n_chk++; if (pc_in !== 32'h104) $display("FAIL nrdy_accept_pc_in: got %h want %h", pc_in, 32'h104); else n_pass++;
        tick();
        ready = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL nrdy_wait_req: got %b want 0", bus.imem_req_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== 32'h1000_0100) $display("FAIL nrdy_ifid: got %b %h %h want 1 100 10000100", if_id_valid, if_id_pc, if_id_instr); else n_pass++;
    endtask

    task automatic test_stall_skid();
        do_reset();
        mem_auto = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0; man_v = 1'b1; man_d = 32'hAAAA_0001;
        tick();
        man_v = 1'b0; ready = 1'b1; stall = 1'b1;
        tick();
        ready = 1'b0; man_v = 1'b1; man_d = 32'h0000_0013;
        tick();
        man_v = 1'b0;
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hAAAA_0001 || if_id_pc !== 32'h0) $display("FAIL skid_hold_ifid: got %b %h %h want 1 aaaa0001 0", if_id_valid, if_id_instr, if_id_pc); else n_pass++;
        n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL skid_hold_req: got %b want 0", bus.imem_req_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (if_id_instr !== 32'hAAAA_0001 || bus.imem_req_valid !== 1'b0) $display("FAIL skid_hold2: got %h req=%b want aaaa0001 0", if_id_instr, bus.imem_req_valid); else n_pass++;
        stall = 1'b0;
        tick();
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h13 || if_id_pc !== 32'h4) $display("FAIL skid_release: got %b %h %h want 1 13 4", if_id_valid, if_id_instr, if_id_pc); else n_pass++;
        n_chk++; if (bus.imem_req_valid !== 1'b1) $display("FAIL skid_back_req: got %b want 1", bus.imem_req_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b0) $display("FAIL skid_drain: got %b want 0", if_id_valid); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_auto = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0203;
        @(negedge clk);
        n_chk++; if (pc_in !== 32'h200) $display("FAIL rdw_pc_in: got %h want %h", pc_in, 32'h200); else n_pass++;
        tick();
        redirect_valid = 1'b0; man_v = 1'b1; man_d = 32'hDEAD_BEEF;
        @(negedge clk);
        n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rdw_drop_req: got %b want 0", bus.imem_req_valid); else n_pass++;
        tick();
        man_v = 1'b0; ready = 1'b1;
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b0) $display("FAIL rdw_dropped: got %b want 0", if_id_valid); else n_pass++;
        n_chk++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200 || pc_in !== 32'h204) $display("FAIL rdw_next_req: got %b %h %h want 1 200 204", bus.imem_req_valid, bus.imem_req_addr, pc_in); else n_pass++;
        tick();
        ready = 1'b0; man_v = 1'b1; man_d = 32'h0000_0055;
        tick();
        man_v = 1'b0;
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || if_id_instr !== 32'h55) $display("FAIL rdw_ifid: got %b %h %h want 1 200 55", if_id_valid, if_id_pc, if_id_instr); else n_pass++;
    endtask

    task automatic test_redirect_edges();
        // Redirect and response in the same WAIT_RSP cycle.
        do_reset();
        mem_auto = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40; man_v = 1'b1; man_d = 32'h77;
        tick();
        redirect_valid = 1'b0; man_v = 1'b0;
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) $display("FAIL rd_rsp_same: got %b %b %h want 0 1 40", if_id_valid, bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
        // Redirect in REQ while the request is accepted.
        do_reset();
        mem_auto = 1'b0; ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
        @(negedge clk);
        n_chk++; if (pc_in !== 32'h80) $display("FAIL rd_req_pc_in: got %h want %h", pc_in, 32'h80); else n_pass++;
        tick();
        ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rd_req_drop: got %b want 0", bus.imem_req_valid); else n_pass++;
        man_v = 1'b1; man_d = 32'h99;
        tick();
        man_v = 1'b0;
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h80) $display("FAIL rd_req_after: got %b %b %h want 0 1 80", if_id_valid, bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        mem_auto = 1'b0; pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC;
        tick();
        pc_load = 1'b0; ready = 1'b1;
        @(negedge clk);
        n_chk++; if (pc_in !== 32'h0 || bus.imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_in: got %h addr=%h want 0 fffffffc", pc_in, bus.imem_req_addr); else n_pass++;
        tick();
        ready = 1'b0; man_v = 1'b1; man_d = 32'h0000_0099;
        tick();
        man_v = 1'b0;
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_ifid_pc: got %b %h want 1 fffffffc", if_id_valid, if_id_pc); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        do_reset();
        mem_auto = 1'b1; ready = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || bus.imem_req_valid !== 1'b0) $display("FAIL rs_setup: got %b %h req=%b want 1 0 0", if_id_valid, if_id_pc, bus.imem_req_valid); else n_pass++;
        redirect_valid = 1'b1; redirect_target = 32'h300;
        @(negedge clk);
        n_chk++; if (pc_in !== 32'h300) $display("FAIL rs_pc_in: got %h want %h", pc_in, 32'h300); else n_pass++;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b0) $display("FAIL rs_flush: got %b want 0", if_id_valid); else n_pass++;
        stall = 1'b0;
        tick();
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h300) $display("FAIL rs_skid_gone: got %b %b %h want 0 1 300", if_id_valid, bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_auto = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0; reset = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.imem_req_valid !== 1'b0 || pc_in !== 32'h0) $display("FAIL rm_in_reset: got req=%b pc_in=%h want 0 0", bus.imem_req_valid, pc_in); else n_pass++;
        tick();
        reset = 1'b1; man_v = 1'b1; man_d = 32'h42;
        @(negedge clk);
        n_chk++; if (bus.imem_req_valid !== 1'b1) $display("FAIL rm_req_state: got %b want 1", bus.imem_req_valid); else n_pass++;
        tick();
        man_v = 1'b0;
        @(negedge clk);
        n_chk++; if (if_id_valid !== 1'b0 || bus.imem_req_valid !== 1'b1) $display("FAIL rm_stale_ignored: got %b req=%b want 0 1", if_id_valid, bus.imem_req_valid); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ready_hold();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_edges();
        test_wrap();
        test_redirect_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address, driven on pc_in during reset.
REQ-002 Parameter PC_STEP, 4, sequential address increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; low at a rising clk edge resets the block.
REQ-005 pc_out  input  32  current PC from program_counter.
REQ-006 pc_in  output  32  next PC to program_counter, combinational.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  instruction memory accepts request.
REQ-009 imem_req_addr  output  32  fetch address, equals pc_out.
REQ-010 imem_rsp_valid  input  1  instruction word returned, one cycle pulse.
REQ-011 imem_rsp_data  input  32  instruction word.
REQ-012 redirect_valid  input  1  branch/jump taken or flush.
REQ-013 redirect_target  input  32  redirect address.
REQ-014 stall  input  1  decode not accepting; IF/ID outputs hold.
REQ-015 if_id_valid  output  1  IF/ID register holds valid instruction.
REQ-016 if_id_instr  output  32  fetched instruction.
REQ-017 if_id_pc  output  32  address of if_id_instr.

Function
REQ-018 FSM states SHALL be REQ, WAIT_RSP, HOLD, DROP; at most one request outstanding.
REQ-019 REQ: imem_req_valid=1; on valid&ready SHALL capture pc_out into req_pc, drive pc_in=pc_out+PC_STEP (mod 2^32), go WAIT_RSP; otherwise pc_in=pc_out.
REQ-020 WAIT_RSP/HOLD/DROP: imem_req_valid=0, pc_in=pc_out.
REQ-021 WAIT_RSP, rsp_valid, stall=0 or if_id_valid=0: load if_id_instr=rsp_data, if_id_pc=req_pc, if_id_valid=1 next cycle; go REQ.
REQ-022 WAIT_RSP, rsp_valid, stall=1 and if_id_valid=1: capture rsp_data/req_pc into skid buffer; go HOLD.
REQ-023 HOLD: when stall=0, skid moves to IF/ID register next cycle; go REQ.
REQ-024 IF/ID register SHALL hold when stall=1; with stall=0 and no new word, if_id_valid SHALL clear next cycle.
REQ-025 DROP: next rsp_valid SHALL be discarded; go REQ.
REQ-026 redirect_valid SHALL override all: pc_in=redirect_target with bits[1:0] forced 0; if_id_valid and skid cleared next cycle regardless of stall.
REQ-027 Redirect in WAIT_RSP, or in REQ with request accepted same cycle, SHALL go DROP; in DROP stay DROP; otherwise go REQ.
REQ-028 Redirect with rsp_valid in same WAIT_RSP cycle: response discarded, next state REQ.
REQ-029 pc_out=32'hFFFF_FFFC accepted SHALL yield pc_in=32'h0000_0000 (wrap).

Reset
REQ-030 During reset: pc_in=RESET_VECTOR, imem_req_valid=0, if_id_valid=0, if_id_instr=0, if_id_pc=0, skid empty, state REQ.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; first response after release while in REQ SHALL be ignored.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum typedef, RESET_VECTOR default and PC_STEP default.
REQ-033 Skid buffer SHALL be sub-module fetch_skid_buf (1 entry, 64 bits: instr+pc, valid flag).

Verification
REQ-034 Reset low 2 cycles -> pc_in=0, if_id_valid=0; release, ready=1, 1-cycle memory -> if_id_pc 0,4,8 on successive fetches.
REQ-035 pc_out=32'h100, ready=0 for 3 cycles -> req_valid held, addr=32'h100, pc_in=32'h100 throughout.
REQ-036 if_id_valid=1, stall=1, rsp_data=32'h0000_0013 arrives -> IF/ID unchanged, state HOLD; stall=0 -> if_id_instr=32'h13 next cycle.
REQ-037 Redirect to 32'h0000_0203 during WAIT_RSP -> pc_in=32'h200, following response dropped, next request addr 32'h200.
REQ-038 pc_out=32'hFFFF_FFFC accepted -> pc_in=32'h0000_0000.
REQ-039 Redirect with stall=1 and if_id_valid=1 -> if_id_valid=0 next cycle.
